// File: rtl/port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : port_arbiter_pkg                                           |
// | Description : Shared widths and FSM state encoding for port_arbiter.     |
// |               Carries the packet-buffer geometry (length field width,    |
// |               RAM depth) so the interface and the arbiter agree on it.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package port_arbiter_pkg;

  localparam int pFIFO_WIDTH = 10;                  // packet length field width
  localparam int pDEPTH_RAM  = 1024;                // packet RAM depth
  localparam int lpADDR_W    = $clog2(pDEPTH_RAM);  // start address width

  typedef enum logic [1:0] {
    lpIDLE     = 2'd0,
    lpGRANT    = 2'd1,
    lpWAIT_REQ = 2'd2,
    lpOUT      = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : port_arbiter_if                                            |
// | Description : Bundle of ingress-port and copy-engine signals of the      |
// |               round-robin port arbiter.                                  |
// |   slave  modport : arbiter side                                          |
// |     in  i_pkt_pending, i_request, i_length, i_start_adress, i_ready      |
// |     out o_w_permition, o_valid, o_length, o_start_adress, o_port_num,    |
// |         o_timeout, o_spurious                                            |
// |   master modport : environment side (directions mirrored)                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface port_arbiter_if import port_arbiter_pkg::*; #(
  parameter int pPORTS  = 4,
  parameter int pFLEN_W = pFIFO_WIDTH,
  parameter int pADDR_W = lpADDR_W
);

  logic [pPORTS-1:0]         i_pkt_pending;
  logic [pPORTS-1:0]         i_request;
  logic [pPORTS*pFLEN_W-1:0] i_length;
  logic [pPORTS*pADDR_W-1:0] i_start_adress;
  logic [pPORTS-1:0]         o_w_permition;
  logic                      o_valid;
  logic                      i_ready;
  logic [pFLEN_W-1:0]        o_length;
  logic [pADDR_W-1:0]        o_start_adress;
  logic [$clog2(pPORTS)-1:0] o_port_num;
  logic                      o_timeout;
  logic                      o_spurious;

  modport slave (
    input  i_pkt_pending, i_request, i_length, i_start_adress, i_ready,
    output o_w_permition, o_valid, o_length, o_start_adress, o_port_num,
           o_timeout, o_spurious
  );

  modport master (
    output i_pkt_pending, i_request, i_length, i_start_adress, i_ready,
    input  o_w_permition, o_valid, o_length, o_start_adress, o_port_num,
           o_timeout, o_spurious
  );

endinterface
`default_nettype wire

// File: rtl/port_arbiter_rr_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_select                                                  |
// | Description : Combinational round-robin priority search. Scans i_req     |
// |               starting at i_start and wrapping, returns the first set    |
// |               bit's index.                                               |
// |   in  i_req   [pPORTS]  request vector                                   |
// |   in  i_start [IDX_W]   index with highest priority                      |
// |   out o_idx   [IDX_W]   winner index (0 when nothing found)              |
// |   out o_found           at least one request bit set                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_select #(
  parameter int pPORTS = 4,
  parameter int pIDX_W = $clog2(pPORTS)
) (
  input  logic [pPORTS-1:0] i_req,
  input  logic [pIDX_W-1:0] i_start,
  output logic [pIDX_W-1:0] o_idx,
  output logic              o_found
);

  logic [pIDX_W-1:0] w_k;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = '0;
    for (int i = 0; i < pPORTS; i++) begin
      // modulo keeps the wrap correct for non power-of-two port counts
      w_k = pIDX_W'((int'(i_start) + i) % pPORTS);
      if (!o_found && i_req[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : port_arbiter                                               |
// | Description : Round-robin ingress arbiter. Grants one pending port with  |
// |               a one-cycle write-permission pulse, captures the packet    |
// |               descriptor from that port's request pulse and offers it    |
// |               to the copy engine over valid/ready. One descriptor in     |
// |               flight at a time; grants not answered within pTIMEOUT      |
// |               cycles are abandoned.                                      |
// |   in  iclk   clock, rising edge                                          |
// |   in  i_rst  asynchronous active-low reset                               |
// |   bus port_arbiter_if.slave (ingress ports + descriptor handshake)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module port_arbiter import port_arbiter_pkg::*; #(
  parameter int pPORTS   = 4,
  parameter int pTIMEOUT = 64
) (
  input  logic          iclk,
  input  logic          i_rst,
  port_arbiter_if.slave bus
);

  localparam int lpIDX_W = $clog2(pPORTS);
  localparam int lpCNT_W = $clog2(pTIMEOUT + 1);

  state_t               r_state,   w_state_nxt;
  logic [lpIDX_W-1:0]   r_last,    w_last_nxt;
  logic [lpIDX_W-1:0]   r_gnt,     w_gnt_nxt;
  logic [lpCNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [pPORTS-1:0]    r_perm,    w_perm_nxt;
  logic                 r_valid,   w_valid_nxt;
  logic [pFIFO_WIDTH-1:0] r_length, w_length_nxt;
  logic [lpADDR_W-1:0]  r_addr,    w_addr_nxt;
  logic [lpIDX_W-1:0]   r_port,    w_port_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_spur,    w_spur_nxt;

  logic [lpIDX_W-1:0]   w_start;
  logic [lpIDX_W-1:0]   w_win;
  logic                 w_found;
  logic [pPORTS-1:0]    w_gnt_mask;
  logic                 w_req_hit;
  logic [lpCNT_W-1:0]   w_cnt_inc;

  assign w_start    = (r_last == lpIDX_W'(pPORTS - 1)) ? '0 : r_last + 1'b1;
  assign w_gnt_mask = pPORTS'(1) << r_gnt;
  assign w_req_hit  = |(bus.i_request & w_gnt_mask);
  assign w_cnt_inc  = r_cnt + 1'b1;

  rr_select #(.pPORTS(pPORTS), .pIDX_W(lpIDX_W)) u_rr_select (
    .i_req   (bus.i_pkt_pending),
    .i_start (w_start),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gnt_nxt     = r_gnt;
    w_cnt_nxt     = r_cnt;
    w_perm_nxt    = '0;
    w_valid_nxt   = r_valid;
    w_length_nxt  = r_length;
    w_addr_nxt    = r_addr;
    w_port_nxt    = r_port;
    w_timeout_nxt = 1'b0;
    // any request not from the current grant holder is flagged, whatever the state
    w_spur_nxt    = |(bus.i_request & ~w_gnt_mask);

    case (r_state)
      lpIDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_win;
          w_perm_nxt  = pPORTS'(1) << w_win;
          w_state_nxt = lpGRANT;
        end
      end
      lpGRANT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = lpWAIT_REQ;
      end
      lpWAIT_REQ: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_req_hit) begin
          w_length_nxt = bus.i_length[r_gnt*pFIFO_WIDTH +: pFIFO_WIDTH];
          w_addr_nxt   = bus.i_start_adress[r_gnt*lpADDR_W +: lpADDR_W];
          w_port_nxt   = r_gnt;
          w_last_nxt   = r_gnt;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = lpOUT;
        end else if (w_cnt_inc == lpCNT_W'(pTIMEOUT - 1)) begin
          // counter reaching pTIMEOUT-1 lands the registered pulse exactly
          // pTIMEOUT cycles after the GRANT cycle
          w_timeout_nxt = 1'b1;
          w_last_nxt    = r_gnt;
          w_state_nxt   = lpIDLE;
        end
      end
      lpOUT: begin
        if (bus.i_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = lpIDLE;
        end
      end
      default: w_state_nxt = lpIDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= lpIDLE;
      r_last    <= lpIDX_W'(pPORTS - 1);  // port 0 gets first priority
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_perm    <= '0;
      r_valid   <= 1'b0;
      r_length  <= '0;
      r_addr    <= '0;
      r_port    <= '0;
      r_timeout <= 1'b0;
      r_spur    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt     <= w_gnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_perm    <= w_perm_nxt;
      r_valid   <= w_valid_nxt;
      r_length  <= w_length_nxt;
      r_addr    <= w_addr_nxt;
      r_port    <= w_port_nxt;
      r_timeout <= w_timeout_nxt;
      r_spur    <= w_spur_nxt;
    end
  end

  assign bus.o_w_permition  = r_perm;
  assign bus.o_valid        = r_valid;
  assign bus.o_length       = r_length;
  assign bus.o_start_adress = r_addr;
  assign bus.o_port_num     = r_port;
  assign bus.o_timeout      = r_timeout;
  assign bus.o_spurious     = r_spur;

endmodule
`default_nettype wire
